// File: rtl/fifo_uart_tx_if.sv
// Handshake between the byte FIFO / transmit control side and the UART drain stage.
// master drives enable and FIFO head signals; slave is the serialiser.
interface fifo_uart_tx_if #(
    parameter int WIDTH = 8
);
    logic             tx_enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_read;
    logic             tx;
    logic             busy;
    logic             frame_done;

    modport master (
        output tx_enable, fifo_empty, fifo_data,
        input  fifo_read, tx, busy, frame_done
    );

    modport slave (
        input  tx_enable, fifo_empty, fifo_data,
        output fifo_read, tx, busy, frame_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops a first-word-fall-through FIFO and serialises each word
// as a UART frame (start, data LSB first, optional parity, stop bits), back-to-back.
module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input logic           clk,
    input logic           rst_n,
    fifo_uart_tx_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state;
    logic [CW-1:0]    baud_cnt;
    logic [BW-1:0]    bit_idx;
    logic             stop_idx;
    logic [WIDTH-1:0] shreg;
    logic             parity;

    logic          bit_end;
    logic          last_stop;
    logic          launch;
    logic [BW-1:0] next_idx;

    always_comb begin
        bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
        last_stop = (state == STOP) && bit_end && (stop_idx == 1'(STOP_BITS - 1));
        // Launch from idle or in the final stop cycle so frames run with no idle gap.
        launch    = bus.tx_enable && !bus.fifo_empty && ((state == IDLE) || last_stop);
        next_idx  = bit_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            baud_cnt       <= '0;
            bit_idx        <= '0;
            stop_idx       <= 1'b0;
            shreg          <= '0;
            parity         <= 1'b0;
            bus.tx         <= 1'b1;
            bus.fifo_read  <= 1'b0;
            bus.busy       <= 1'b0;
            bus.frame_done <= 1'b0;
        end else begin
            bus.fifo_read  <= 1'b0;
            bus.frame_done <= 1'b0;

            if (launch) begin
                state         <= START;
                baud_cnt      <= '0;
                bit_idx       <= '0;
                stop_idx      <= 1'b0;
                shreg         <= bus.fifo_data;
                parity        <= (^bus.fifo_data) ^ 1'(PARITY_ODD);
                bus.tx        <= 1'b0;
                bus.fifo_read <= 1'b1;
                bus.busy      <= 1'b1;
            end

            case (state)
                IDLE: ;
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        bus.tx   <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == BW'(WIDTH - 1)) begin
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                bus.tx <= parity;
                            end else begin
                                state    <= STOP;
                                stop_idx <= 1'b0;
                                bus.tx   <= 1'b1;
                            end
                        end else begin
                            bit_idx <= next_idx;
                            bus.tx  <= shreg[next_idx];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        stop_idx <= 1'b0;
                        bus.tx   <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (last_stop) begin
                        bus.frame_done <= 1'b1;
                        if (!launch) begin
                            state    <= IDLE;
                            baud_cnt <= '0;
                            bus.tx   <= 1'b1;
                            bus.busy <= 1'b0;
                        end
                    end else if (bit_end) begin
                        baud_cnt <= '0;
                        stop_idx <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations driven from emulated FIFOs and checked
// cycle by cycle against a frame-level model built from the expected bit sequence.
module tb_fifo_uart_tx;
    localparam int N = 3;
    localparam int unsigned CPB [N] = '{4, 4, 3};
    localparam int unsigned PEN [N] = '{0, 1, 1};
    localparam int unsigned ODD [N] = '{0, 0, 1};
    localparam int unsigned STP [N] = '{1, 1, 2};

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    always #5 clk = ~clk;

    logic [7:0]  fmem [N][64];
    int unsigned head [N];
    int unsigned tail [N];
    int unsigned left [N];
    logic [15:0] fbits [N];
    logic        exp_rd [N];
    logic        exp_done [N];
    int          n_cmp;
    int          n_fail;
    int          cyc;

    logic o_tx [N];
    logic o_rd [N];
    logic o_busy [N];
    logic o_done [N];

    fifo_uart_tx_if #(.WIDTH(8)) if0 ();
    fifo_uart_tx_if #(.WIDTH(8)) if1 ();
    fifo_uart_tx_if #(.WIDTH(8)) if2 ();

    assign if0.tx_enable  = en;
    assign if0.fifo_empty = (head[0] == tail[0]);
    assign if0.fifo_data  = fmem[0][head[0] % 64];
    assign if1.tx_enable  = en;
    assign if1.fifo_empty = (head[1] == tail[1]);
    assign if1.fifo_data  = fmem[1][head[1] % 64];
    assign if2.tx_enable  = en;
    assign if2.fifo_empty = (head[2] == tail[2]);
    assign if2.fifo_data  = fmem[2][head[2] % 64];

    assign o_tx[0] = if0.tx;  assign o_rd[0] = if0.fifo_read;
    assign o_busy[0] = if0.busy;  assign o_done[0] = if0.frame_done;
    assign o_tx[1] = if1.tx;  assign o_rd[1] = if1.fifo_read;
    assign o_busy[1] = if1.busy;  assign o_done[1] = if1.frame_done;
    assign o_tx[2] = if2.tx;  assign o_rd[2] = if2.fifo_read;
    assign o_busy[2] = if2.busy;  assign o_done[2] = if2.frame_done;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    function automatic int unsigned flen(input int d);
        return (9 + PEN[d] + STP[d]) * CPB[d];
    endfunction

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push(input int d, input logic [7:0] v);
        if (tail[d] - head[d] < 60) begin
            fmem[d][tail[d] % 64] = v;
            tail[d]++;
        end
    endtask

    task automatic push_all(input logic [7:0] v);
        for (int d = 0; d < N; d++) push(d, v);
    endtask

    // One clock: predict launches from pre-edge inputs, advance the model, then compare.
    task automatic step();
        bit          launch [N];
        bit          pop [N];
        logic [7:0]  w;
        logic        etx;
        for (int d = 0; d < N; d++) begin
            launch[d] = rst_n && en && (head[d] != tail[d]) && (left[d] <= 1);
            pop[d]    = o_rd[d] && (head[d] != tail[d]);
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < N; d++) begin
            exp_done[d] = rst_n && (left[d] == 1);
            exp_rd[d]   = launch[d];
            if (!rst_n) begin
                left[d] = 0;
            end else if (launch[d]) begin
                w         = fmem[d][head[d] % 64];
                fbits[d]  = '1;
                fbits[d][0] = 1'b0;
                for (int i = 0; i < 8; i++) fbits[d][1 + i] = w[i];
                if (PEN[d] != 0) fbits[d][9] = 1'(($countones(w) + ODD[d]) % 2);
                left[d] = flen(d);
            end else if (left[d] > 0) begin
                left[d]--;
            end
            if (pop[d]) head[d]++;
        end
        #1;
        for (int d = 0; d < N; d++) begin
            etx = (left[d] > 0) ? fbits[d][(flen(d) - left[d]) / CPB[d]] : 1'b1;
            chk($sformatf("d%0d_tx@%0d", d, cyc), o_tx[d], etx);
            chk($sformatf("d%0d_read@%0d", d, cyc), o_rd[d], exp_rd[d]);
            chk($sformatf("d%0d_busy@%0d", d, cyc), o_busy[d], left[d] > 0);
            chk($sformatf("d%0d_done@%0d", d, cyc), o_done[d], exp_done[d]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int d = 0; d < N; d++) begin
            head[d] = 0; tail[d] = 0; left[d] = 0; fbits[d] = '1;
        end
        rst_n = 1'b0;
        en    = 1'b0;
        run(3);
        rst_n = 1'b1;
        run(2);

        // Single frames: 0xA5 on all, then 0x00/0xFF back-to-back and parity byte 0x07.
        en = 1'b1;
        push_all(8'hA5);
        run(60);
        push(0, 8'h00); push(0, 8'hFF);
        push(1, 8'h07); push(2, 8'h07);
        run(100);

        // Long empty stretch, then a word arrives.
        run(100);
        push_all(8'h3C);
        run(60);

        // Drop enable during data bit 2 with three words queued.
        push_all(8'h11); push_all(8'h22); push_all(8'h33);
        run(14);
        en = 1'b0;
        run(120);
        en = 1'b1;
        run(200);

        // Asynchronous reset during data bit 3.
        push_all(8'h12);
        run(18);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < N; d++) begin
            chk($sformatf("d%0d_rst_tx", d), o_tx[d], 1'b1);
            chk($sformatf("d%0d_rst_read", d), o_rd[d], 1'b0);
            chk($sformatf("d%0d_rst_busy", d), o_busy[d], 1'b0);
            chk($sformatf("d%0d_rst_done", d), o_done[d], 1'b0);
            left[d] = 0;
        end
        #1;
        rst_n = 1'b1;
        push_all(8'h55);
        run(60);

        // Random traffic with occasional enable toggles.
        for (int i = 0; i < 1500; i++) begin
            for (int d = 0; d < N; d++)
                if ($urandom_range(19, 0) == 0) push(d, 8'($urandom));
            if ($urandom_range(149, 0) == 0) en = ~en;
            step();
        end
        en = 1'b1;
        run(300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
